// File: rtl/tinyvga_rx.sv
// tinyvga_rx: TinyVGA PMOD receive monitor; define TINYVGA_RX_CRC_EN to add a per-frame CRC-16/CCITT.
// state | meaning: SEARCH | await VSYNC fall, TRACK | first frame under check, LOCKED | timing verified
module tinyvga_rx #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [5:0] pix_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
`ifdef TINYVGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LOST = 11'(2 * H_TOTAL);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_LOST = 11'(2 * V_TOTAL);
  localparam logic [10:0] HA_LO  = 11'(H_START);
  localparam logic [10:0] HA_HI  = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] VA_LO  = 11'(V_START);
  localparam logic [10:0] VA_HI  = 11'(V_START + V_ACTIVE);
  localparam logic [9:0]  H_OFS  = 10'(H_START);
  localparam logic [9:0]  V_OFS  = 10'(V_START);

  logic [7:0]  s1_q, s2_q;
  logic [10:0] hcnt_q, vcnt_q;
  state_t      state_q;
  logic        first_q;
  logic        vs_fall_q;
  logic        frame_start_q;
  logic        locked_q;
  logic [7:0]  err_count_q;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [5:0]  pix_rgb_q, pix_rgb_d;
  logic        hs_fall, vs_fall, checking, timing_err;

  assign hs_fall  = s2_q[7] & ~s1_q[7];
  assign vs_fall  = s2_q[3] & ~s1_q[3];
  assign checking = (state_q != SEARCH);

  // The first HSYNC fall after acquiring VSYNC may end a partial line, so it is not checked.
  assign timing_err = checking &&
                      ((hs_fall && !first_q && hcnt_q != H_LAST) ||
                       (hcnt_q == H_LOST) ||
                       (vs_fall && vcnt_q != V_LAST) ||
                       (vcnt_q == V_LOST));

  always_comb begin
    pix_valid_d = checking && (hcnt_q >= HA_LO) && (hcnt_q < HA_HI) &&
                  (vcnt_q >= VA_LO) && (vcnt_q < VA_HI);
    pix_x_d     = pix_valid_d ? (hcnt_q[9:0] - H_OFS) : '0;
    pix_y_d     = pix_valid_d ? (vcnt_q[9:0] - V_OFS) : '0;
    pix_rgb_d   = pix_valid_d ? {s2_q[0], s2_q[4], s2_q[1], s2_q[5], s2_q[2], s2_q[6]} : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q          <= 8'hFF;
      s2_q          <= 8'hFF;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      state_q       <= SEARCH;
      first_q       <= 1'b1;
      vs_fall_q     <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      s1_q          <= vga_in;
      s2_q          <= s1_q;
      hcnt_q        <= hs_fall ? 11'd0 : hcnt_q + 11'd1;
      if (vs_fall)
        vcnt_q <= '0;
      else if (hs_fall)
        vcnt_q <= vcnt_q + 11'd1;
      vs_fall_q     <= vs_fall;
      frame_start_q <= vs_fall_q;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      if (timing_err && err_count_q != 8'hFF)
        err_count_q <= err_count_q + 8'd1;
      case (state_q)
        SEARCH: begin
          first_q  <= 1'b1;
          locked_q <= 1'b0;
          if (vs_fall)
            state_q <= TRACK;
        end
        TRACK: begin
          if (hs_fall)
            first_q <= 1'b0;
          if (timing_err) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end else if (vs_fall) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (hs_fall)
            first_q <= 1'b0;
          if (timing_err) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

`ifdef TINYVGA_RX_CRC_EN
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  logic [15:0] crc_q, crc_base, crc_d, frame_crc_q;
  logic        crc_valid_q, last_pix;

  // Accumulator restarts on every frame boundary so a frame cut short by an error cannot leak in.
  assign crc_base = frame_start_q ? 16'hFFFF : crc_q;
  assign crc_d    = crc_byte(crc_base, {2'b00, pix_rgb_q});
  assign last_pix = pix_valid_q && (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= last_pix;
      crc_q       <= pix_valid_q ? crc_d : crc_base;
      if (last_pix)
        frame_crc_q <= crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`endif

endmodule

// File: doc/tinyvga_rx.md
# tinyvga_rx

Receive-side monitor for the TinyVGA PMOD output of our TT demo designs (640x480@60 timing, 2-bit-per-channel colour). It samples the 8-bit `uo_out` bundle in the same clock domain, recovers horizontal/vertical position from the sync pulses, validates line and frame timing, and emits a pixel stream with coordinates. It sits in the verification/loopback path, downstream of the demo top-level's `uo_out`.

## Interface
Parameters:
- `H_TOTAL`, 800, clocks from one HSYNC falling edge to the next
- `H_START`, 144, clocks from HSYNC falling edge to first active pixel (sync + back porch)
- `H_ACTIVE`, 640, active pixels per line
- `V_TOTAL`, 525, lines from one VSYNC falling edge to the next
- `V_START`, 35, lines from VSYNC falling edge to first active line
- `V_ACTIVE`, 480, active lines per frame

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `vga_in`  in  8  PMOD bundle: [0]R1 [1]G1 [2]B1 [3]VSYNC [4]R0 [5]G0 [6]B0 [7]HSYNC; syncs active-low
- `pix_valid`  out  1  active pixel on `pix_rgb` this cycle
- `pix_x`  out  10  column, 0..H_ACTIVE-1
- `pix_y`  out  10  row, 0..V_ACTIVE-1
- `pix_rgb`  out  6  {R1,R0,G1,G0,B1,B0}
- `frame_start`  out  1  one-cycle pulse on each VSYNC falling edge
- `locked`  out  1  one full frame of correct timing seen
- `err_count`  out  8  timing errors, saturating at 255

## Operation
- `vga_in` registered twice (s1, s2); falling edge = s2 high and s1 low.
- `hcnt`: 0 on the cycle an HSYNC fall is detected, else +1. `vcnt`: +1 per HSYNC fall; 0 on VSYNC fall (VSYNC fall takes priority when coincident).
- FSM states:
  - SEARCH: wait for VSYNC fall -> TRACK. No pixel output.
  - TRACK: check timing; at next VSYNC fall with no error -> LOCKED.
  - LOCKED: keep checking; `locked`=1.
- Timing errors (TRACK or LOCKED): HSYNC fall with `hcnt`≠H_TOTAL-1 (first fall after entering TRACK exempt); `hcnt` reaching 2*H_TOTAL (lost hsync); VSYNC fall with `vcnt`≠V_TOTAL-1; `vcnt` reaching 2*V_TOTAL. On error: `err_count`+1 (saturate at 255), go to SEARCH.
- Active region: `hcnt` in [H_START, H_START+H_ACTIVE) and `vcnt` in [V_START, V_START+V_ACTIVE), state TRACK or LOCKED. `pix_x`=hcnt-H_START, `pix_y`=vcnt-V_START, else both 0.
- `frame_start` pulses in every state, including SEARCH.

## Timing
- Reset: all outputs 0, FSM SEARCH, counters 0, sync history registers 1 (idle level).
- Latency: a `vga_in` sample at cycle n is reflected on `pix_*` at cycle n+3 (2 sync stages + registered output). `frame_start` has the same latency relative to the VSYNC edge.
- `locked` falls the cycle after the error is detected. `err_count` updates that same cycle.
- Reset mid-frame: immediate return to reset state; nothing is held over.
- Counters are 11 bits internally. Width is checked against 2*H_TOTAL and 2*V_TOTAL.

## Configuration
- `TINYVGA_RX_CRC_EN` defined: adds outputs `frame_crc` (16) and `crc_valid` (1).
  - CRC-16/CCITT (poly 0x1021, init 0xFFFF) over {2'b00,`pix_rgb`} of every `pix_valid` pixel in raster order.
  - Result latched and `crc_valid` pulsed for 1 cycle on the pixel after the last active pixel of the frame. Reset value is 0.
- Undefined: ports absent, no CRC logic.

## Test plan
Small parameters: H_TOTAL=20, H_START=4, H_ACTIVE=8, V_TOTAL=12, V_START=2, V_ACTIVE=6, HSYNC width 2, VSYNC width 1 line.
- Reset, then 3 correct frames with `rgb` = x -> `frame_start` pulses once per frame (every 240 clk); `locked`=1 after second VSYNC fall; `err_count`=0.
- Pixel check, locked -> 48 `pix_valid` cycles per frame; `pix_x` 0..7, `pix_y` 0..5; `pix_rgb` matches the input 3 cycles earlier.
- Shorten one line to 19 clk -> `locked` drops, `err_count`=1, no `pix_valid` until the next VSYNC fall, relock after one clean frame.
- Hold HSYNC high for 45 clk -> lost-hsync error at `hcnt`=40, `err_count`+1.
- Inject 300 errors -> `err_count` stays at 255. Assert `rst` mid-line -> all outputs 0 that cycle, asynchronously.
- `TINYVGA_RX_CRC_EN`, all-zero pixels -> `crc_valid` once per frame with `frame_crc` equal to the CRC-16/CCITT of 48 zero bytes. Bench compares against a model.
